// File: rtl/edge_gen_pkg.sv
// Shared types for the edge generator: FSM states, request decode, counter width.
// Optional counter outputs are enabled with the EDGE_GEN_CNT_EN macro.
package edge_gen_pkg;

    typedef enum logic [1:0] {GEN_IDLE, GEN_HOLD, GEN_HOLD_PEND} gen_state_e;
    typedef enum logic [1:0] {REQ_NONE, REQ_RISE, REQ_FALL, REQ_BOTH} edge_req_e;

    localparam int unsigned EDGE_CNT_W = 16;

    // Rise in bit 0 and fall in bit 1 map directly onto edge_req_e.
    function automatic edge_req_e decode_req(input logic rise, input logic fall);
        return edge_req_e'({fall, rise});
    endfunction

endpackage

// File: rtl/edge_generator_if.sv
// Request/level bundle between a requester (master) and edge_generator (slave).
// Signals: rise_req_i, fall_req_i (requests); level_o, rising_edge_o,
// falling_edge_o, busy_o, drop_o (status); rise_cnt_o/fall_cnt_o when
// EDGE_GEN_CNT_EN is defined.
interface edge_generator_if;
    import edge_gen_pkg::*;

    logic rise_req_i;
    logic fall_req_i;
    logic level_o;
    logic rising_edge_o;
    logic falling_edge_o;
    logic busy_o;
    logic drop_o;
`ifdef EDGE_GEN_CNT_EN
    logic [EDGE_CNT_W-1:0] rise_cnt_o;
    logic [EDGE_CNT_W-1:0] fall_cnt_o;
`endif

`ifdef EDGE_GEN_CNT_EN
    modport master (output rise_req_i, fall_req_i,
                    input  level_o, rising_edge_o, falling_edge_o, busy_o, drop_o,
                           rise_cnt_o, fall_cnt_o);
    modport slave  (input  rise_req_i, fall_req_i,
                    output level_o, rising_edge_o, falling_edge_o, busy_o, drop_o,
                           rise_cnt_o, fall_cnt_o);
`else
    modport master (output rise_req_i, fall_req_i,
                    input  level_o, rising_edge_o, falling_edge_o, busy_o, drop_o);
    modport slave  (input  rise_req_i, fall_req_i,
                    output level_o, rising_edge_o, falling_edge_o, busy_o, drop_o);
`endif

endinterface

// File: rtl/edge_hold_timer.sv
// Minimum-hold down-counter: load sets MIN_HOLD-1, then counts down to 0.
// Ports: clk, reset (sync, active-high), load (edge issued),
// expired (count is 0), last (count is 1, reaching 0 next cycle unless reloaded).
module edge_hold_timer #(
    parameter int unsigned MIN_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired,
    output logic last
);

    localparam int unsigned CNT_W = ($clog2(MIN_HOLD + 1) > 1) ? $clog2(MIN_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MIN_HOLD - 1);

    logic [CNT_W-1:0] cnt_q;

    // Load wins over decrement; zero is sticky until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired = (cnt_q == '0);
    assign last    = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/edge_generator.sv
// Turns one-cycle rise/fall request pulses into a level with a minimum hold
// time between edges, one buffered request, and per-edge strobes.
// Ports: clk, reset (sync, active-high), bus (edge_generator_if.slave).
// Optional: EDGE_GEN_CNT_EN adds saturating rise/fall edge counters.
module edge_generator
    import edge_gen_pkg::*;
#(
    parameter int unsigned MIN_HOLD    = 4,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    edge_generator_if.slave   bus
);

    gen_state_e state_q, state_n;
    edge_req_e  req;
    logic       level_q, rise_q, fall_q, busy_q, drop_q;
    logic       want_vld, want_lvl, pend;
    logic       issue, cancel, set_pend, pend_n, hold_n;
    logic       expired, last;

    edge_hold_timer #(.MIN_HOLD(MIN_HOLD)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (issue),
        .expired (expired),
        .last    (last)
    );

    // Request evaluation against current level and any buffered request.
    always_comb begin
        issue    = 1'b0;
        cancel   = 1'b0;
        set_pend = 1'b0;
        req      = decode_req(bus.rise_req_i, bus.fall_req_i);
        want_vld = (req == REQ_RISE) || (req == REQ_FALL);
        want_lvl = (req == REQ_RISE);
        pend     = (state_q == GEN_HOLD_PEND);
        if (pend) begin
            // Asking for the current level again undoes the buffered edge.
            if (want_vld && (want_lvl == level_q)) begin
                cancel = 1'b1;
            end else if (expired) begin
                issue = 1'b1;
            end
        end else if (want_vld && (want_lvl != level_q)) begin
            if (expired) begin
                issue = 1'b1;
            end else begin
                set_pend = 1'b1;
            end
        end
        pend_n  = (pend && !cancel && !issue) || set_pend;
        // Hold counter nonzero next cycle?
        hold_n  = issue ? (MIN_HOLD > 1) : (!expired && !last);
        state_n = pend_n ? GEN_HOLD_PEND : (hold_n ? GEN_HOLD : GEN_IDLE);
    end

    // State, level and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GEN_IDLE;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            busy_q  <= (state_n != GEN_IDLE);
            drop_q  <= (req == REQ_BOTH);
            rise_q  <= issue && !level_q;
            fall_q  <= issue && level_q;
            if (issue) begin
                level_q <= ~level_q;
            end
        end
    end

    assign bus.level_o        = level_q;
    assign bus.rising_edge_o  = rise_q;
    assign bus.falling_edge_o = fall_q;
    assign bus.busy_o         = busy_q;
    assign bus.drop_o         = drop_q;

`ifdef EDGE_GEN_CNT_EN
    logic [EDGE_CNT_W-1:0] rise_cnt_q, fall_cnt_q;

    // Saturating counts of issued edges only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
        end else if (issue) begin
            if (!level_q && (rise_cnt_q != '1)) begin
                rise_cnt_q <= rise_cnt_q + EDGE_CNT_W'(1);
            end
            if (level_q && (fall_cnt_q != '1)) begin
                fall_cnt_q <= fall_cnt_q + EDGE_CNT_W'(1);
            end
        end
    end

    assign bus.rise_cnt_o = rise_cnt_q;
    assign bus.fall_cnt_o = fall_cnt_q;
`endif

endmodule
